// File: rtl/dmem_pipe_hs.sv
// Data memory with valid/ready request and response channels, a fixed-latency read pipe and a credit-managed response FIFO.
// Define DMEM_ERR_RESP_EN to flag out-of-range and misaligned requests through rsp_err_o.

package memory_pkg;
  localparam int unsigned DMEM_SIZE_BYTES = 1024;
  localparam logic [31:0] MAP_DMEM_BASE   = 32'h0001_0000;
endpackage

module dmem_pipe_hs #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       MEM_SIZE  = memory_pkg::DMEM_SIZE_BYTES,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(memory_pkg::MAP_DMEM_BASE),
  parameter int unsigned       LATENCY   = 1,
  parameter int unsigned       RSP_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned LSB   = $clog2(BYTES);
  localparam int unsigned WORDS = MEM_SIZE / BYTES;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  logic              accept;
  logic              pop;
  logic              req_ready_q, req_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] idx;
  logic [IDX_W-1:0]  widx;
  logic              out_of_range;
  logic              bad;
  logic              err_flag;
  logic              wr_en;
  rsp_t              samp;
  logic              push_v;
  rsp_t              push_d;

  assign accept = req_valid_i && req_ready_q;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign offset       = req_addr_i - BASE_ADDR;
  assign idx          = offset >> LSB;
  assign widx         = idx[IDX_W-1:0];
  assign out_of_range = (req_addr_i < BASE_ADDR) || (idx >= ADDR_W'(WORDS));

`ifdef DMEM_ERR_RESP_EN
  logic misaligned;
  assign misaligned = (req_addr_i & ADDR_W'(BYTES - 1)) != '0;
  assign bad        = out_of_range || misaligned;
  assign err_flag   = bad;
`else
  // Low address bits fall away in the shift above, so alignment is forced.
  assign bad      = out_of_range;
  assign err_flag = 1'b0;
`endif

  assign wr_en = accept && req_we_i && !bad;

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [WORDS];

  // NOTE: the array has no reset so it maps onto RAM; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int unsigned k = 0; k < BYTES; k++) begin
        if (req_be_i[k]) mem_q[widx][8*k +: 8] <= req_wdata_i[8*k +: 8];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    samp.err   = err_flag;
    samp.rdata = '0;
    if (!req_we_i && !bad) samp.rdata = mem_q[widx];
  end

  // ---------------------------------------------------------------------------
  // Latency pipe: LATENCY-1 register stages between the array and the FIFO
  // ---------------------------------------------------------------------------
  if (LATENCY == 1) begin : g_nopipe
    assign push_v = accept;
    assign push_d = samp;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld_q;
    rsp_t               dat_q [LATENCY-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= accept;
        for (int unsigned s = 1; s < LATENCY - 1; s++) vld_q[s] <= vld_q[s-1];
      end
    end

    always_ff @(posedge clk_i) begin
      dat_q[0] <= samp;
      for (int unsigned s = 1; s < LATENCY - 1; s++) dat_q[s] <= dat_q[s-1];
    end

    assign push_v = vld_q[LATENCY-2];
    assign push_d = dat_q[LATENCY-2];
  end

  // ---------------------------------------------------------------------------
  // Response FIFO; the credit counter guarantees a push never meets a full FIFO
  // ---------------------------------------------------------------------------
  rsp_t             fifo_q [RSP_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  rsp_t             head;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_v) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_v) fifo_q[wr_ptr_q[PTR_W-1:0]] <= push_d;
  end

  assign head        = fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign rsp_valid_o = (wr_ptr_q != rd_ptr_q);
  assign pop         = rsp_valid_o && rsp_ready_i;
  // Gate with valid so stale FIFO contents never reach the outputs.
  assign rsp_rdata_o = rsp_valid_o ? head.rdata : '0;
  assign rsp_err_o   = rsp_valid_o && head.err;

  // ---------------------------------------------------------------------------
  // Credits: outstanding = pipe + FIFO occupancy; ready is registered
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!accept && pop) cnt_d = cnt_q - 1'b1;
    req_ready_d = (cnt_d < CNT_W'(RSP_DEPTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready_o = req_ready_q;

endmodule

// File: tb/tb_dmem_pipe_hs.sv
// Self-checking bench for dmem_pipe_hs: a LATENCY=1/RSP_DEPTH=2 instance and a LATENCY=2/RSP_DEPTH=4 instance
// checked against an in-order memory/response model.

module tb_dmem_pipe_hs;
  import memory_pkg::*;

  localparam logic [31:0] BASE  = MAP_DMEM_BASE;
  localparam int          WORDS = DMEM_SIZE_BYTES / 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  logic        req_valid [2];
  logic        req_we    [2];
  logic [3:0]  req_be    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_ready [2];
  wire         req_ready [2];
  wire         rsp_valid [2];
  wire  [31:0] rsp_rdata [2];
  wire         rsp_err   [2];

  dmem_pipe_hs #(.LATENCY(1), .RSP_DEPTH(2)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_be_i(req_be[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
  );

  dmem_pipe_hs #(.LATENCY(2), .RSP_DEPTH(4)) u_dut_l2 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_be_i(req_be[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
  );

`ifdef DMEM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Reference model: word array plus an in-order queue of expected responses
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mdl_mem [2][WORDS];
  int          acc_cnt [2];
  int          rsp_cnt [2];
  logic [31:0] last_rd [2];
  logic        last_err[2];
  logic        hold_v  [2];
  logic [31:0] hold_rd [2];
  logic        hold_err[2];

  function automatic exp_t model(int d, logic we, logic [3:0] be, logic [31:0] addr, logic [31:0] wdata);
    exp_t e;
    logic oob, bad;
    int   w;
    oob = (addr < BASE) || (((addr - BASE) >> 2) >= 32'(WORDS));
    bad = oob || (ERR_EN && (addr[1:0] != 2'b00));
    e.err = ERR_EN && bad;
    e.rd  = '0;
    if (!bad) begin
      w = int'((addr - BASE) >> 2);
      if (we) begin
        for (int k = 0; k < 4; k++)
          if (be[k]) mdl_mem[d][w][8*k +: 8] = wdata[8*k +: 8];
      end else begin
        e.rd = mdl_mem[d][w];
      end
    end
    return e;
  endfunction

  function automatic void push_exp(int d, exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic bit pop_exp(int d, output exp_t e);
    e.rd = '0; e.err = 1'b0;
    if (d == 0) begin
      if (q0.size() == 0) return 1'b0;
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) return 1'b0;
      e = q1.pop_front();
    end
    return 1'b1;
  endfunction

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Monitor: samples on the falling edge, between active edges.
  always @(negedge clk) begin
    if (rst) begin
      hold_v[0] = 1'b0;
      hold_v[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        bit   have;
        if (hold_v[d] && rsp_valid[d]) begin
          checks++;
          if (rsp_rdata[d] !== hold_rd[d] || rsp_err[d] !== hold_err[d]) begin
            errors++;
            $display("FAIL hold dut%0d: got %h/%b, held value %h/%b", d, rsp_rdata[d], rsp_err[d], hold_rd[d], hold_err[d]);
          end
        end
        hold_v[d]   = rsp_valid[d] && !rsp_ready[d];
        hold_rd[d]  = rsp_rdata[d];
        hold_err[d] = rsp_err[d];
        if (rsp_valid[d] && rsp_ready[d]) begin
          have = pop_exp(d, e);
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL unexpected_rsp dut%0d: got %h/%b, required none", d, rsp_rdata[d], rsp_err[d]);
          end else if (rsp_rdata[d] !== e.rd || rsp_err[d] !== e.err) begin
            errors++;
            $display("FAIL rsp dut%0d: got %h/%b, required %h/%b", d, rsp_rdata[d], rsp_err[d], e.rd, e.err);
          end
          last_rd[d]  = rsp_rdata[d];
          last_err[d] = rsp_err[d];
          rsp_cnt[d]++;
        end
        if (req_valid[d] && req_ready[d]) begin
          push_exp(d, model(d, req_we[d], req_be[d], req_addr[d], req_wdata[d]));
          acc_cnt[d]++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers: called and returning at posedge+1
  // ---------------------------------------------------------------------------
  task automatic send(input int d, input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, input int budget, output bit ok);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_be[d]    = be;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    ok = 1'b0;
    for (int t = 0; t < budget && !ok; t++) begin
      @(negedge clk);
      if (req_ready[d]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid[d] = 1'b0;
  endtask

  task automatic send_chk(input int d, input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata);
    bit ok;
    send(d, we, be, addr, wdata, 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout dut%0d: addr %h not accepted within 100 cycles", d, addr);
    end
  endtask

  task automatic drain(input int d);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (qsize(d) == 0 && !rsp_valid[d]) done = 1'b1;
    end
    @(posedge clk);
    #1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain dut%0d: %0d responses outstanding, required 0", d, qsize(d));
    end
  endtask

  task automatic expect_last(input string name, input int d, input logic [31:0] rd, input logic err);
    checks++;
    if (last_rd[d] !== rd || last_err[d] !== err) begin
      errors++;
      $display("FAIL %s dut%0d: got %h/%b, required %h/%b", name, d, last_rd[d], last_err[d], rd, err);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_be[d] = '0;
      req_addr[d]  = '0;   req_wdata[d] = '0; rsp_ready[d] = 1'b1;
      acc_cnt[d] = 0; rsp_cnt[d] = 0; last_rd[d] = '0; last_err[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]} !== 35'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: ready=%b valid=%b err=%b rdata=%h, required all 0",
                 d, req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]);
      end
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_reset dut%0d: got %b, required 1", d, req_ready[d]);
      end
    end
  endtask

  task automatic test_store_load();
    send_chk(0, 1'b1, 4'hF, BASE + 32'h10, 32'hDEADBEEF);
    send_chk(0, 1'b0, 4'h0, BASE + 32'h10, 32'h0);
    checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_load_latency: valid=%b rdata=%h one cycle after accept, required 1/deadbeef",
               rsp_valid[0], rsp_rdata[0]);
    end
    drain(0);
  endtask

  task automatic test_byte_lanes();
    send_chk(0, 1'b1, 4'hF,    BASE + 32'h20, 32'h11223344);
    send_chk(0, 1'b1, 4'b0100, BASE + 32'h20, 32'hAABBCCDD);
    send_chk(0, 1'b0, 4'h0,    BASE + 32'h20, 32'h0);
    drain(0);
    expect_last("byte_lane", 0, 32'h11BB3344, 1'b0);
    send_chk(0, 1'b1, 4'h0,    BASE + 32'h20, 32'hFFFFFFFF);
    send_chk(0, 1'b0, 4'h0,    BASE + 32'h20, 32'h0);
    drain(0);
    expect_last("be_zero", 0, 32'h11BB3344, 1'b0);
  endtask

  task automatic test_errors();
    send_chk(0, 1'b1, 4'hF, BASE, 32'h55667788);
    send_chk(0, 1'b0, 4'h0, BASE + 32'(DMEM_SIZE_BYTES), 32'h0);
    drain(0);
    expect_last("oob_read", 0, 32'h0, ERR_EN);
    send_chk(0, 1'b0, 4'h0, BASE - 32'h4, 32'h0);
    drain(0);
    expect_last("below_base_read", 0, 32'h0, ERR_EN);
    send_chk(0, 1'b1, 4'hF, BASE + 32'h2, 32'hCAFEF00D);
    drain(0);
    expect_last("misaligned_write", 0, 32'h0, ERR_EN);
    send_chk(0, 1'b0, 4'h0, BASE, 32'h0);
    drain(0);
    expect_last("after_misaligned", 0, ERR_EN ? 32'h55667788 : 32'hCAFEF00D, 1'b0);
  endtask

  task automatic test_backpressure();
    bit ok;
    int acc0, rsp0;
    for (int i = 0; i < 6; i++) send_chk(1, 1'b1, 4'hF, BASE + 32'h40 + 32'(4*i), 32'hA5000000 + 32'(i));
    drain(1);
    rsp_ready[1] = 1'b0;
    acc0 = acc_cnt[1];
    rsp0 = rsp_cnt[1];
    for (int i = 0; i < 4; i++) send_chk(1, 1'b0, 4'h0, BASE + 32'h40 + 32'(4*i), 32'h0);
    send(1, 1'b0, 4'h0, BASE + 32'h50, 32'h0, 10, ok);
    checks++;
    if (ok || acc_cnt[1] - acc0 != 4 || req_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_stall: accepted=%0d ready=%b fifth_taken=%b, required 4/0/0",
               acc_cnt[1] - acc0, req_ready[1], ok);
    end
    rsp_ready[1] = 1'b1;
    send_chk(1, 1'b0, 4'h0, BASE + 32'h50, 32'h0);
    send_chk(1, 1'b0, 4'h0, BASE + 32'h54, 32'h0);
    drain(1);
    checks++;
    if (acc_cnt[1] - acc0 != 6 || rsp_cnt[1] - rsp0 != 6) begin
      errors++;
      $display("FAIL backpressure_release: accepted=%0d responses=%0d, required 6/6",
               acc_cnt[1] - acc0, rsp_cnt[1] - rsp0);
    end
    expect_last("backpressure_last", 1, 32'hA5000005, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    int seen;
    rsp_ready[1] = 1'b0;
    for (int i = 0; i < 3; i++) send_chk(1, 1'b0, 4'h0, BASE + 32'h40 + 32'(4*i), 32'h0);
    checks++;
    if (rsp_valid[1] !== 1'b1) begin
      errors++;
      $display("FAIL burst_pending: valid=%b before reset, required 1", rsp_valid[1]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid[1] !== 1'b0 || rsp_valid[0] !== 1'b0 || req_ready[1] !== 1'b0 || req_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b/%b ready=%b/%b, required all 0",
               rsp_valid[0], rsp_valid[1], req_ready[0], req_ready[1]);
    end
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    rsp_ready[1] = 1'b1;
    seen = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (rsp_valid[1]) seen++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL stale_response: %0d valid cycles after reset, required 0", seen);
    end
    send_chk(1, 1'b0, 4'h0, BASE + 32'h40, 32'h0);
    drain(1);
    expect_last("retained_dut1", 1, 32'hA5000000, 1'b0);
    send_chk(0, 1'b0, 4'h0, BASE + 32'h10, 32'h0);
    drain(0);
    expect_last("retained_dut0", 0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_streaming(input int d);
    int          start;
    int          sel;
    logic [31:0] addr;
    rsp_ready[d] = 1'b1;
    start = cyc;
    for (int i = 0; i < 16; i++) send_chk(d, 1'b1, 4'hF, BASE + 32'h100 + 32'(4*i), $urandom);
    for (int i = 0; i < 64; i++) begin
      sel = int'($urandom_range(0, 19));
      if (sel < 16)       addr = BASE + 32'h100 + 32'(4*sel);
      else if (sel == 16) addr = BASE + 32'(DMEM_SIZE_BYTES) + 32'(4*$urandom_range(0, 3));
      else if (sel == 17) addr = BASE - 32'h4;
      else                addr = BASE + 32'h100 + 32'(4*$urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      send_chk(d, 1'($urandom_range(0, 1)), 4'($urandom), addr, $urandom);
    end
    checks++;
    if (cyc - start != 80) begin
      errors++;
      $display("FAIL throughput dut%0d: 80 requests took %0d cycles, required 80", d, cyc - start);
    end
    drain(d);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid_burst();
    test_streaming(0);
    test_streaming(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
